port_arbiter: RTL and testbench

PORT_ARBITER -- requirements
Module: port_arbiter

---
 rtl/port_arbiter_pkg.sv | 12 +
 rtl/port_arbiter_onehot_decoder.sv | 19 +
 rtl/port_arbiter.sv | 120 ++++++++++++
 tb/tb_port_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/port_arbiter_pkg.sv
// Shared definitions for the round-robin port arbiter: FSM encoding and default sizing.
package port_arbiter_pkg;

    localparam int PA_PORT_NUM_DEF = 8;
    localparam int PA_TIMEOUT_DEF  = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } pa_state_e;

endpackage

// File: rtl/port_arbiter_onehot_decoder.sv
// One-hot to binary index conversion; all-zero input yields index 0.
module onehot_decoder #(
    parameter int ONE_HOT_WIDTH = 8,
    parameter int BIN_W         = $clog2(ONE_HOT_WIDTH)
) (
    input  logic [ONE_HOT_WIDTH-1:0] onehot_in,
    output logic [BIN_W-1:0]         bin_out
);

    always_comb begin
        bin_out = '0;
        for (int i = 0; i < ONE_HOT_WIDTH; i++) begin
            if (onehot_in[i]) begin
                bin_out = bin_out | BIN_W'(i);
            end
        end
    end

endmodule

// File: rtl/port_arbiter.sv
// Round-robin arbiter holding a registered one-hot grant until last beat, request drop
// or an idle timeout, with zero-gap handover to the next requester.
//
// state | meaning
// IDLE  | no grant outstanding, waiting for any req bit
// BUSY  | one port granted, watching for a release event
module port_arbiter
    import port_arbiter_pkg::*;
#(
    parameter int PORT_NUM = PA_PORT_NUM_DEF,
    parameter int TIMEOUT  = PA_TIMEOUT_DEF,
    parameter int IDX_W    = $clog2(PORT_NUM)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PORT_NUM-1:0] req,
    input  logic                xfer_vld,
    input  logic                xfer_last,
    output logic [PORT_NUM-1:0] gnt,
    output logic [IDX_W-1:0]    gnt_idx,
    output logic                gnt_vld,
    output logic                timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    pa_state_e           state_q, state_d;
    logic [PORT_NUM-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_q, timeout_d;

    logic [CNT_W-1:0]    cnt_inc;
    logic                rel_last, rel_drop, rel_tmo;

    // Lowest rotated offset wins: scanning offsets high-to-low lets the last hit stand.
    function automatic logic [PORT_NUM-1:0] pick_next(
        input logic [PORT_NUM-1:0] r,
        input logic [IDX_W-1:0]    p
    );
        logic [IDX_W-1:0] j;
        pick_next = '0;
        for (int i = PORT_NUM - 1; i >= 0; i--) begin
            j = p + IDX_W'(i);
            if (r[j]) begin
                pick_next    = '0;
                pick_next[j] = 1'b1;
            end
        end
    endfunction

    onehot_decoder #(
        .ONE_HOT_WIDTH (PORT_NUM)
    ) u_gnt_dec (
        .onehot_in (gnt_q),
        .bin_out   (gnt_idx)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        cnt_inc  = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
        rel_last = xfer_vld & xfer_last;
        rel_drop = ~|(req & gnt_q);
        rel_tmo  = ~xfer_vld & (cnt_inc == CNT_W'(TIMEOUT));

        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = pick_next(req, ptr_q);
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = xfer_vld ? '0 : cnt_inc;
                if (rel_last || rel_drop || rel_tmo) begin
                    ptr_d     = gnt_idx + IDX_W'(1);
                    timeout_d = ~rel_last & ~rel_drop;
                    cnt_d     = '0;
                    if (|req) begin
                        gnt_d = pick_next(req, ptr_d);
                    end else begin
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = |gnt_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_port_arbiter.sv
// Directed bench for port_arbiter (8 ports, TIMEOUT=4) with a queued expectation scoreboard.
module tb_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       xfer_vld;
    logic       xfer_last;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       tmo;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    port_arbiter #(
        .PORT_NUM (8),
        .TIMEOUT  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .xfer_vld  (xfer_vld),
        .xfer_last (xfer_last),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_vld   (gnt_vld),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input exp_t e);
        chk({tag, ".gnt"},     32'(gnt),            32'(e.gnt));
        chk({tag, ".idx"},     32'(gnt_idx),        32'(e.idx));
        chk({tag, ".vld"},     32'(gnt_vld),        32'(e.gnt != 8'h00));
        chk({tag, ".tmo"},     32'(timeout),        32'(e.tmo));
        chk({tag, ".onehot"},  32'($onehot0(gnt)),  32'd1);
    endtask

    // Drive one cycle of stimulus, queue what the outputs must look like after the edge.
    task automatic step(input string tag, input logic [7:0] r, input logic xv, input logic xl,
                        input logic [7:0] eg, input logic [2:0] ei, input logic et);
        exp_t  e;
        string t;
        req       = r;
        xfer_vld  = xv;
        xfer_last = xl;
        sb_q.push_back('{gnt: eg, idx: ei, tmo: et});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        chk_outputs(t, e);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 8'h00;
        xfer_vld  = 1'b0;
        xfer_last = 1'b0;
        @(posedge clk);
        #1;
        chk_outputs("reset", '{gnt: 8'h00, idx: 3'd0, tmo: 1'b0});
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) step("idle_noreq", 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);

        // ptr=0: port 2 first, last beat hands straight over to port 5
        step("grant_p2",    8'h24, 1'b0, 1'b0, 8'h04, 3'd2, 1'b0);
        step("handover_p5", 8'h24, 1'b1, 1'b1, 8'h20, 3'd5, 1'b0);
        step("drop_idle",   8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);

        // ptr=6: grant 7, drop req[7] with req[0] up -> port 0, ptr wraps to 0
        step("grant_p7",    8'h80, 1'b0, 1'b0, 8'h80, 3'd7, 1'b0);
        step("wrap_p0",     8'h01, 1'b0, 1'b0, 8'h01, 3'd0, 1'b0);

        for (int i = 1; i <= 8; i++) begin
            step("rr_ff", 8'hFF, 1'b1, 1'b1, 8'(1 << (i % 8)), 3'(i % 8), 1'b0);
        end
        step("rr_end",      8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);

        // ptr=1: port 3 granted, no beats, released by the idle counter after 4 cycles
        step("tmo_grant",   8'h18, 1'b0, 1'b0, 8'h08, 3'd3, 1'b0);
        step("tmo_wait1",   8'h18, 1'b0, 1'b0, 8'h08, 3'd3, 1'b0);
        step("tmo_wait2",   8'h18, 1'b0, 1'b0, 8'h08, 3'd3, 1'b0);
        step("tmo_wait3",   8'h18, 1'b0, 1'b0, 8'h08, 3'd3, 1'b0);
        step("tmo_fire",    8'h18, 1'b0, 1'b0, 8'h10, 3'd4, 1'b1);
        step("tmo_pulse1",  8'h10, 1'b0, 1'b0, 8'h10, 3'd4, 1'b0);
        step("tmo_xv_clr",  8'h10, 1'b1, 1'b0, 8'h10, 3'd4, 1'b0);
        step("tmo_w1",      8'h10, 1'b0, 1'b0, 8'h10, 3'd4, 1'b0);
        step("tmo_w2",      8'h10, 1'b0, 1'b0, 8'h10, 3'd4, 1'b0);
        step("tmo_w3",      8'h10, 1'b0, 1'b0, 8'h10, 3'd4, 1'b0);
        step("tmo_self",    8'h10, 1'b0, 1'b0, 8'h10, 3'd4, 1'b1);
        step("tmo_s1",      8'h10, 1'b0, 1'b0, 8'h10, 3'd4, 1'b0);
        step("tmo_s2",      8'h10, 1'b0, 1'b0, 8'h10, 3'd4, 1'b0);
        step("tmo_s3",      8'h10, 1'b0, 1'b0, 8'h10, 3'd4, 1'b0);
        step("drop_vs_tmo", 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
        step("idle_xfer",   8'h00, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0);

        // ptr=5: grant 5, then reset in the middle of BUSY
        step("pre_rst",     8'h20, 1'b0, 1'b0, 8'h20, 3'd5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs("rst_async", '{gnt: 8'h00, idx: 3'd0, tmo: 1'b0});
        @(posedge clk);
        #1;
        chk_outputs("rst_hold", '{gnt: 8'h00, idx: 3'd0, tmo: 1'b0});
        rst_n = 1'b1;
        #1;
        step("post_rst_p2", 8'h84, 1'b0, 1'b0, 8'h04, 3'd2, 1'b0);
        step("post_rst_p7", 8'h80, 1'b0, 1'b0, 8'h80, 3'd7, 1'b0);
        step("post_rst_no_tmo", 8'h80, 1'b0, 1'b0, 8'h80, 3'd7, 1'b0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
